// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU control codes, opcodes, decoded-entry type and funct3 mapping
package alu_issue_pkg;
  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } entry_t;
  localparam entry_t ENTRY_RST = {ALU_ADD, 71'd0};
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic sub_ok);
    case (f3)
      3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I integer-ALU decode into an issue entry
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output entry_t      dec
);
  logic [2:0] f3;
  logic [6:0] f7;
  logic shift, sh_ok;
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign shift = f3 == 3'b001 || f3 == 3'b101;
  assign sh_ok = f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000);
  always_comb begin
    dec = ENTRY_RST;
    dec.rd = instr[11:7];
    case (instr[6:0])
      OPC_OP: begin
        dec.alu_ctrl = alu_of(f3, instr[30], 1'b1);
        dec.operand1 = rs1_data;
        dec.operand2 = rs2_data;
      end
      OPC_OPIMM: if (shift && !sh_ok) dec.illegal = 1'b1;
      else begin
        dec.alu_ctrl = alu_of(f3, instr[30], 1'b0);
        dec.operand1 = rs1_data;
        dec.operand2 = shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LUI: begin
        dec.alu_ctrl = ALU_LUI;
        dec.operand2 = {instr[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        dec.operand1 = pc;
        dec.operand2 = {instr[31:12], 12'h000};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_write = !dec.illegal && dec.rd != 5'd0;
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode-to-ALU issue buffer with valid/ready handshakes and flush
// ALU_ISSUE_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal,
  input  logic        flush
);
  entry_t dec, q;
  logic acc;
  alu_issue_decode u_dec (.instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .dec(dec));
  assign acc = in_valid && in_ready;
  assign {alu_ctrl, operand1, operand2, rd, reg_write, illegal} = q;
`ifdef ALU_ISSUE_SKID_EN
  entry_t skid;
  logic skid_valid;
  // the skid slot fills only while the output is stalled, so it alone marks "full"
  assign in_ready = !rst && !skid_valid;
  always_ff @(posedge clk)
    if (rst) begin
      q <= ENTRY_RST;
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) q <= skid;
      else if (acc) q <= dec;
      out_valid <= skid_valid || acc;
      skid_valid <= 1'b0;
    end else if (acc) begin
      skid <= dec;
      skid_valid <= 1'b1;
    end
`else
  assign in_ready = !rst && (!out_valid || out_ready);
  always_ff @(posedge clk)
    if (rst) begin
      q <= ENTRY_RST;
      out_valid <= 1'b0;
    end else if (flush) out_valid <= 1'b0;
    else if (!out_valid || out_ready) begin
      out_valid <= acc;
      if (acc) q <= dec;
    end
`endif
endmodule
